// File: rtl/pipereg_stage.sv
// Generic inter-stage pipeline register with a valid/ready handshake.
// SKID=1 gives a two-entry skid buffer whose in_ready does not depend on out_ready or stall.
// SKID=0 gives a single register whose in_ready is combinational.
// It also supports a synchronous flush, a stall/hold input and a saturating stall-cycle counter.
module pipereg_stage #(
   parameter int unsigned       DATA_W    = 64,
   parameter logic [DATA_W-1:0] RESET_VAL = '0,
   parameter int unsigned       SKID      = 1,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              stall,
   input  logic              flush,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              cnt_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic              w_go;
   logic              w_take;
   logic              w_give;
   logic              w_in_ready;

   assign w_go   = out_ready & ~stall;
   assign w_take = in_valid & w_in_ready;
   assign w_give = r_out_valid & w_go;

   generate
      if (SKID != 0) begin : g_skid
         logic              r_sk_valid;
         logic [DATA_W-1:0] r_sk_data;

         // in_ready comes from a flop, so out_ready and stall have no combinational path to it.
         // Gating with reset holds in_ready low while reset is asserted.
         // After release, in_ready is already high for the first edge.
         assign w_in_ready = ~r_sk_valid & reset;

         // Main/skid state: flush kills both entries, and a full skid refills main on give.
         always_ff @(posedge clk or negedge reset) begin
            // NOTE: payload registers are reset to a known value on purpose, so no X reaches out_data.
            // Sequential state is updated only with non-blocking assignments.
            if (!reset) begin
               r_out_valid <= 1'b0;
               r_out_data  <= RESET_VAL;
               r_sk_valid  <= 1'b0;
               r_sk_data   <= RESET_VAL;
            end else if (flush) begin
               r_out_valid <= 1'b0;
               r_sk_valid  <= 1'b0;
            end else if (r_sk_valid) begin
               if (w_give) begin
                  r_out_data <= r_sk_data;
                  r_sk_valid <= 1'b0;
               end
            end else if (w_take) begin
               if (!r_out_valid || w_give) begin
                  r_out_data  <= in_data;
                  r_out_valid <= 1'b1;
               end else begin
                  r_sk_data  <= in_data;
                  r_sk_valid <= 1'b1;
               end
            end else if (w_give) begin
               r_out_valid <= 1'b0;
            end
         end
      end else begin : g_reg
         // The slot frees up in the same cycle it is drained, which gives full throughput.
         assign w_in_ready = w_go | ~r_out_valid;

         // Single register: load on take, empty on give, otherwise hold.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_out_valid <= 1'b0;
               r_out_data  <= RESET_VAL;
            end else if (flush) begin
               r_out_valid <= 1'b0;
            end else if (w_take) begin
               r_out_data  <= in_data;
               r_out_valid <= 1'b1;
            end else if (w_give) begin
               r_out_valid <= 1'b0;
            end
         end
      end
   endgenerate

   // Count cycles where a real payload is waiting but cannot leave; the count saturates instead of wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (cnt_clr) begin
         r_stall_cnt <= '0;
      end else if (r_out_valid && !w_go && !flush && (r_stall_cnt != CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipereg_stage.sv
// Self-checking bench for pipereg_stage.
// The skid instance is checked by a scoreboard queue and a monitor.
// A 2-bit-counter instance checks counter saturation, and a SKID=0 instance checks the bypass path.
module tb_pipereg_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // Main instance: SKID=1, 64-bit payload, 16-bit counter
   logic        sk_in_valid, sk_in_ready, sk_out_valid, sk_out_ready;
   logic        sk_stall, sk_flush, sk_cnt_clr;
   logic [63:0] sk_in_data, sk_out_data;
   logic [15:0] sk_stall_cnt;

   // Saturation instance: SKID=1, 8-bit payload, 2-bit counter
   logic        sa_in_valid, sa_in_ready, sa_out_valid, sa_out_ready;
   logic        sa_stall, sa_flush, sa_cnt_clr;
   logic [7:0]  sa_in_data, sa_out_data;
   logic [1:0]  sa_stall_cnt;

   // Bypass instance: SKID=0, 8-bit payload
   logic        by_in_valid, by_in_ready, by_out_valid, by_out_ready;
   logic        by_stall, by_flush, by_cnt_clr;
   logic [7:0]  by_in_data, by_out_data;
   logic [15:0] by_stall_cnt;

   pipereg_stage #(.DATA_W(64), .RESET_VAL(64'h8000_0000), .SKID(1), .CNT_W(16)) u_sk (
      .clk(clk), .reset(reset), .in_valid(sk_in_valid), .in_ready(sk_in_ready),
      .in_data(sk_in_data), .out_valid(sk_out_valid), .out_ready(sk_out_ready),
      .out_data(sk_out_data), .stall(sk_stall), .flush(sk_flush),
      .stall_cnt(sk_stall_cnt), .cnt_clr(sk_cnt_clr));

   pipereg_stage #(.DATA_W(8), .RESET_VAL(8'hA5), .SKID(1), .CNT_W(2)) u_sa (
      .clk(clk), .reset(reset), .in_valid(sa_in_valid), .in_ready(sa_in_ready),
      .in_data(sa_in_data), .out_valid(sa_out_valid), .out_ready(sa_out_ready),
      .out_data(sa_out_data), .stall(sa_stall), .flush(sa_flush),
      .stall_cnt(sa_stall_cnt), .cnt_clr(sa_cnt_clr));

   pipereg_stage #(.DATA_W(8), .RESET_VAL(8'h3C), .SKID(0), .CNT_W(16)) u_by (
      .clk(clk), .reset(reset), .in_valid(by_in_valid), .in_ready(by_in_ready),
      .in_data(by_in_data), .out_valid(by_out_valid), .out_ready(by_out_ready),
      .out_data(by_out_data), .stall(by_stall), .flush(by_flush),
      .stall_cnt(by_stall_cnt), .cnt_clr(by_cnt_clr));

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a transfer happens on the coming edge when out_valid & out_ready & ~stall (flush excluded).
   always @(negedge clk) begin
      if (reset && sk_out_valid && sk_out_ready && !sk_stall && !sk_flush) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %h, expected no output", sk_out_data);
         end else begin
            check("sb_data", sk_out_data, exp_q.pop_front());
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int   budget;
      reset = 1'b0;
      {sk_in_valid, sk_out_ready, sk_stall, sk_flush, sk_cnt_clr} = '0;
      {sa_in_valid, sa_out_ready, sa_stall, sa_flush, sa_cnt_clr} = '0;
      {by_in_valid, by_out_ready, by_stall, by_flush, by_cnt_clr} = '0;
      sk_in_data = '0; sa_in_data = '0; by_in_data = '0;
      #12;
      check("rst_out_valid", {63'd0, sk_out_valid}, 64'd0);
      check("rst_out_data", sk_out_data, 64'h8000_0000);
      check("rst_in_ready_skid", {63'd0, sk_in_ready}, 64'd0);
      check("rst_in_ready_byp", {63'd0, by_in_ready}, 64'd1);
      check("rst_sat_data", {56'd0, sa_out_data}, 64'hA5);
      @(negedge clk) reset = 1'b1;
      tick();

      // Streaming: 1..8 back to back, out_ready held high
      sk_out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         sk_in_valid = 1'b1;
         sk_in_data  = 64'(i);
         exp_q.push_back(64'(i));
         @(negedge clk) check("stream_in_ready", {63'd0, sk_in_ready}, 64'd1);
         tick();
         if (i == 1) check("stream_latency", sk_out_data, 64'd1);
      end
      sk_in_valid = 1'b0;
      tick(); tick();
      check("stream_drained", 64'(exp_q.size()), 64'd0);
      check("stream_empty", {63'd0, sk_out_valid}, 64'd0);

      // Backpressure: A, B, C with out_ready low from the cycle A appears
      sk_in_valid = 1'b1; sk_in_data = 64'hAAAA; exp_q.push_back(64'hAAAA);
      tick();
      sk_out_ready = 1'b0;
      sk_in_data = 64'hBBBB; exp_q.push_back(64'hBBBB);
      @(negedge clk) check("bp_b_ready", {63'd0, sk_in_ready}, 64'd1);
      tick();
      check("bp_full_in_ready", {63'd0, sk_in_ready}, 64'd0);
      check("bp_hold_a", sk_out_data, 64'hAAAA);
      sk_in_data = 64'hCCCC; exp_q.push_back(64'hCCCC);
      tick();
      check("bp_c_rejected", {63'd0, sk_in_ready}, 64'd0);
      check("bp_still_a", sk_out_data, 64'hAAAA);
      sk_out_ready = 1'b1;
      budget = 20;
      do begin
         @(negedge clk) acc = sk_in_ready;
         tick();
         budget--;
      end while (!acc && budget > 0);
      check("bp_c_accept_bound", {63'd0, acc}, 64'd1);
      sk_in_valid = 1'b0;
      tick(); tick();
      check("bp_drained", 64'(exp_q.size()), 64'd0);

      // Stall: D held for 5 stalled cycles, then counter cleared
      sk_in_valid = 1'b1; sk_in_data = 64'hDDDD; sk_cnt_clr = 1'b1;
      tick();
      exp_q.push_back(64'hDDDD);
      sk_in_valid = 1'b0; sk_cnt_clr = 1'b0; sk_stall = 1'b1;
      repeat (5) tick();
      check("stall_data", sk_out_data, 64'hDDDD);
      check("stall_valid", {63'd0, sk_out_valid}, 64'd1);
      check("stall_cnt5", {48'd0, sk_stall_cnt}, 64'd5);
      sk_stall = 1'b0; sk_cnt_clr = 1'b1;
      tick();
      check("stall_cnt_clr", {48'd0, sk_stall_cnt}, 64'd0);
      sk_cnt_clr = 1'b0;
      check("stall_drained", 64'(exp_q.size()), 64'd0);

      // Flush: main=A2, skid=B2, C2 offered while flushing
      sk_out_ready = 1'b0;
      sk_in_valid = 1'b1; sk_in_data = 64'hA2;
      tick();
      sk_in_data = 64'hB2;
      tick();
      check("fl_full", {63'd0, sk_in_ready}, 64'd0);
      sk_in_data = 64'hC2; sk_flush = 1'b1;
      tick();
      sk_flush = 1'b0; sk_in_valid = 1'b0;
      check("fl_out_valid", {63'd0, sk_out_valid}, 64'd0);
      check("fl_in_ready", {63'd0, sk_in_ready}, 64'd1);
      check("fl_cnt", {48'd0, sk_stall_cnt}, 64'd1);
      tick();
      check("fl_c_dropped", {63'd0, sk_out_valid}, 64'd0);
      sk_out_ready = 1'b1;

      // Flush while the main entry is empty: the accepted-looking C3 is discarded
      sk_in_valid = 1'b1; sk_in_data = 64'hC3; sk_flush = 1'b1;
      tick();
      sk_in_valid = 1'b0; sk_flush = 1'b0;
      check("fl_take_dropped", {63'd0, sk_out_valid}, 64'd0);

      // Saturation with a 2-bit counter
      sa_in_valid = 1'b1; sa_in_data = 8'h5A; sa_out_ready = 1'b1;
      tick();
      sa_in_valid = 1'b0; sa_stall = 1'b1;
      repeat (10) tick();
      check("sat_cnt", {62'd0, sa_stall_cnt}, 64'd3);
      check("sat_data", {56'd0, sa_out_data}, 64'h5A);

      // SKID=0 bypass
      by_in_valid = 1'b1; by_in_data = 8'h11; by_out_ready = 1'b1;
      tick();
      check("byp_first", {55'd0, by_out_valid, by_out_data}, {55'd0, 1'b1, 8'h11});
      by_in_data = 8'h22;
      @(negedge clk) check("byp_in_ready", {63'd0, by_in_ready}, 64'd1);
      tick();
      check("byp_replace", {55'd0, by_out_valid, by_out_data}, {55'd0, 1'b1, 8'h22});
      by_out_ready = 1'b0;
      #1 check("byp_blocked", {63'd0, by_in_ready}, 64'd0);
      by_out_ready = 1'b1; by_stall = 1'b1;
      #1 check("byp_stalled", {63'd0, by_in_ready}, 64'd0);
      by_stall = 1'b0; by_in_valid = 1'b0;
      tick();
      check("byp_drain", {63'd0, by_out_valid}, 64'd0);

      // Async reset mid-stream with out_valid=1
      sk_out_ready = 1'b0; sk_in_valid = 1'b1; sk_in_data = 64'hEEEE;
      tick();
      sk_in_valid = 1'b0;
      check("rst_pre_valid", {63'd0, sk_out_valid}, 64'd1);
      #2 reset = 1'b0;
      #1;
      check("rst_mid_valid", {63'd0, sk_out_valid}, 64'd0);
      check("rst_mid_data", sk_out_data, 64'h8000_0000);
      check("rst_mid_cnt", {48'd0, sk_stall_cnt}, 64'd0);
      check("rst_mid_in_ready", {63'd0, sk_in_ready}, 64'd0);
      @(negedge clk) reset = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipereg_stage.md
Name: pipereg_stage

Overview:
- Parametrised successor of the fixed EX/MEM pipeline register.
- Generic inter-stage register for any payload width, with a valid/ready handshake, an optional skid buffer, synchronous flush, and a stall/hold input.
- Adds a saturating stall-cycle performance counter.
- Instantiated between every pair of pipeline stages; replaces the per-stage hand-written registers.

Parameters:
DATA_W, 64, payload width in bits (>=1)
RESET_VAL, '0, payload value loaded on reset (DATA_W bits; e.g. PC field 64'h8000_0000 packed by instantiator)
SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single register (combinational in_ready)
CNT_W, 16, width of stall counter (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
in_valid  in  1  upstream has payload
in_ready  out  1  stage can accept payload this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  out_data is a real instruction (0 = bubble)
out_ready  in  1  downstream accepts out_data this cycle
out_data  out  DATA_W  registered payload
stall  in  1  hold request (e.g. Dwait/Iwait); freezes output side
flush  in  1  kill all held payloads (branch/exception)
stall_cnt  out  CNT_W  cycles with out_valid=1 and no transfer due to stall/!out_ready
cnt_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Reset (reset=0, async): out_valid=0, out_data=RESET_VAL, skid valid=0, skid data=RESET_VAL, stall_cnt=0. During reset, in_ready=0 when SKID=1; when SKID=0 it follows its combinational formula (out_valid=0 gives 1). Deassertion is synchronous to clk by the system; first transfer may occur on the first edge after release.
- Definitions: go = out_ready & ~stall; take = in_valid & in_ready; give = out_valid & go.
- SKID=0:
  - in_ready = go | ~out_valid (combinational).
  - On edge: if take, out_data<=in_data and out_valid<=1; else if give, out_valid<=0; else hold.
  - Latency 1 cycle. Full throughput.
- SKID=1:
  - in_ready = ~sk_valid (registered, no combinational path from out_ready/stall).
  - Main empty or give, skid empty, take: in_data -> main.
  - Main full, no give, take: in_data -> skid, sk_valid<=1.
  - give with sk_valid: skid -> main, sk_valid<=0; input is not accepted (in_ready=0).
  - give, no skid, no take: out_valid<=0.
  - Latency 1 cycle; full throughput when go=1 continuously.
  - Order preserved; never more than 2 payloads held.
- stall=1: out_valid/out_data frozen (no give). Input may still fill an empty main or the skid per the rules above. Replaces the old "reload last_dataE" scheme.
- flush=1 (synchronous, priority over stall, take, give): next edge out_valid<=0, sk_valid<=0; in_data that cycle is discarded even if in_valid&in_ready. out_data is not modified (don't-care while out_valid=0). Upstream must not count a flush-cycle handshake as accepted.
- flush and reset both asserted: reset wins.
- stall_cnt, per edge:
  - if cnt_clr: <=0 (priority over increment);
  - else if out_valid & ~go & ~flush: +1, saturating at 2^CNT_W-1 (no wrap);
  - bubbles (out_valid=0) never count.
- No X on outputs after reset; in_data contents are not inspected (payload is opaque).

Test Plan:
- Reset: drive reset=0 mid-stream with out_valid=1 -> immediately out_valid=0, out_data=RESET_VAL (e.g. 64'h8000_0000), stall_cnt=0, independent of clk.
- Streaming: SKID=1, in_valid=1 every cycle with data 1,2,3,..., out_ready=1 -> out_data 1,2,3 one cycle later, one per cycle, in_ready stays 1.
- Backpressure: SKID=1, send A,B,C, hold out_ready=0 from the cycle A appears:
  - out_data=A held; B lands in skid; in_ready=0 next cycle; C not accepted.
  - Release out_ready: out sequence A,B,C with no loss or duplication.
- Stall: stall=1 for 5 cycles with out_valid=1, out_ready=1 -> out_data unchanged and stall_cnt=5; then cnt_clr=1 -> 0. With CNT_W=2, 10 stall cycles -> stall_cnt saturates at 3.
- Flush: main=A, skid=B, in_valid=1 with C, flush=1 -> next cycle out_valid=0, skid empty, C dropped; in_ready=1 again.
- SKID=0 bypass: out_valid=1, out_ready=1, in_valid=1 same cycle -> in_ready=1 combinationally, new data replaces old on the edge, out_valid stays 1.
